// File: rtl/exec_pkg.sv
// Shared types and constants for the multi-cycle execution unit.
// Holds the FSM states, ALU opcodes, addressing modes and BIU transfer kinds.
package exec_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEC,
        S_RDA,
        S_RDB,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam logic [1:0] MODE_IMM  = 2'b00;
    localparam logic [1:0] MODE_RR   = 2'b01;
    localparam logic [1:0] MODE_IMMO = 2'b10;
    localparam logic [1:0] MODE_BAD  = 2'b11;

    localparam logic [1:0] SEL_A  = 2'b00;
    localparam logic [1:0] SEL_B  = 2'b01;
    localparam logic [1:0] SEL_WR = 2'b10;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: add/sub with carry-out, logic ops, shifts, pass-B.
// Shift amount uses only the low log2(DW) bits of B.
module exec_alu
    import exec_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          cout,
    output logic          zero
);

    localparam int SW = $clog2(DW);

    logic [SW-1:0] shamt;
    logic [DW:0]   ext;

    assign shamt = b[SW-1:0];

    always_comb begin
        ext    = '0;
        result = '0;
        cout   = 1'b0;
        unique case (op)
            OP_ADD: begin
                ext    = {1'b0, a} + {1'b0, b};
                result = ext[DW-1:0];
                cout   = ext[DW];
            end
            OP_SUB: begin
                ext    = {1'b0, a} - {1'b0, b};
                result = ext[DW-1:0];
                cout   = ext[DW];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << shamt;
            OP_SHR:  result = a >> shamt;
            OP_PASS: result = b;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execution unit: fetches operands over the BIU, runs the ALU,
// writes the result back; one instruction in flight at a time.
module exec_unit
    import exec_pkg::*;
#(
    parameter int DW  = 16,
    parameter int IRW = 32,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cs,
    input  logic [IRW-1:0] ir,
    output logic           biu_req,
    output logic [1:0]     op_sel,
    input  logic           biu_ready,
    input  logic [DW-1:0]  bus_in,
    output logic [DW-1:0]  bus_out,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           cout,
    output logic           zero
);

    state_t state_q, state_d;

    logic [IRW-1:0] ir_q;
    logic [DW-1:0]  a_q, b_q, res_q;
    logic           cout_q, zero_q, err_q;

    logic [OPW-1:0] op;
    logic [1:0]     mode;
    logic [DW-1:0]  alu_res;
    logic           alu_cout, alu_zero;
    logic           unused_ir;

    assign op        = ir_q[IRW-1 -: OPW];
    assign mode      = ir_q[IRW-OPW-1 -: 2];
    assign unused_ir = ^ir_q;

    exec_alu #(.DW(DW)) u_alu (
        .op     (op[2:0]),
        .a      (a_q),
        .b      (b_q),
        .result (alu_res),
        .cout   (alu_cout),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        biu_req = 1'b0;
        op_sel  = SEL_A;
        unique case (state_q)
            S_IDLE: if (cs) state_d = S_DEC;
            S_DEC: begin
                unique case (mode)
                    MODE_BAD:  state_d = S_IDLE;
                    MODE_IMMO: state_d = S_EXEC;
                    default:   state_d = S_RDA;
                endcase
            end
            S_RDA: begin
                biu_req = 1'b1;
                op_sel  = SEL_A;
                if (biu_ready)
                    state_d = (mode == MODE_RR) ? S_RDB : S_EXEC;
            end
            S_RDB: begin
                biu_req = 1'b1;
                op_sel  = SEL_B;
                if (biu_ready) state_d = S_EXEC;
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                biu_req = 1'b1;
                op_sel  = SEL_WR;
                if (biu_ready) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand/result datapath; A is forced to zero for immediate-only mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: if (cs) ir_q <= ir;
                S_DEC: begin
                    if (mode == MODE_BAD)  err_q <= 1'b1;
                    if (mode != MODE_RR)   b_q   <= ir_q[DW-1:0];
                    if (mode == MODE_IMMO) a_q   <= '0;
                end
                S_RDA: if (biu_ready) a_q <= bus_in;
                S_RDB: if (biu_ready) b_q <= bus_in;
                S_EXEC: begin
                    res_q  <= alu_res;
                    cout_q <= alu_cout;
                    zero_q <= alu_zero;
                end
                default: ;
            endcase
        end
    end

    assign bus_out = res_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign err     = err_q;
    assign cout    = cout_q;
    assign zero    = zero_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: latency, ALU ops, BIU waits, error and reset.
module tb_exec_unit;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic        biu_ready = 1'b0;
    logic [31:0] ir = '0;
    logic [15:0] bus_in;
    logic [15:0] a_val = '0, b_val = '0;
    logic        biu_req, busy, done, err, cout, zero;
    logic [1:0]  op_sel;
    logic [15:0] bus_out;

    int pass_cnt = 0;
    int total_cnt = 0;
    int wait_a = 0;
    int wait_w = 0;
    int bcnt = 0;
    logic [1:0] last_sel = 2'b00;

    logic        cs8 = 1'b0, cs32 = 1'b0, rdy_s = 1'b1;
    logic [31:0] ir8 = '0;
    logic [39:0] ir32 = '0;
    logic [7:0]  bi8, bo8;
    logic [31:0] bi32, bo32;
    logic        req8, busy8, done8, err8, c8, z8;
    logic        req32, busy32, done32, err32, c32, z32;
    logic [1:0]  sel8, sel32;

    logic [2:0]  t_op [7] = '{OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_PASS};
    logic [15:0] t_a  [7] = '{16'h0005, 16'hF0F0, 16'hF0F0, 16'hFF00, 16'h0001, 16'h8000, 16'h1234};
    logic [15:0] t_b  [7] = '{16'h0003, 16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h0013, 16'h000F, 16'hABCD};
    logic [15:0] t_r  [7] = '{16'h0002, 16'h00F0, 16'hFFF0, 16'hF0F0, 16'h0008, 16'h0001, 16'hABCD};

    always #5 clk = ~clk;

    assign bus_in = (op_sel == SEL_B) ? b_val : a_val;
    assign bi8    = (sel8 == SEL_B) ? 8'h07 : 8'h80;
    assign bi32   = (sel32 == SEL_B) ? 32'h0000_001F : 32'h8000_0000;

    exec_unit dut (
        .clk(clk), .rst(rst), .cs(cs), .ir(ir),
        .biu_req(biu_req), .op_sel(op_sel), .biu_ready(biu_ready),
        .bus_in(bus_in), .bus_out(bus_out), .busy(busy), .done(done),
        .err(err), .cout(cout), .zero(zero)
    );

    exec_unit #(.DW(8), .IRW(32)) dut8 (
        .clk(clk), .rst(rst), .cs(cs8), .ir(ir8),
        .biu_req(req8), .op_sel(sel8), .biu_ready(rdy_s),
        .bus_in(bi8), .bus_out(bo8), .busy(busy8), .done(done8),
        .err(err8), .cout(c8), .zero(z8)
    );

    exec_unit #(.DW(32), .IRW(40)) dut32 (
        .clk(clk), .rst(rst), .cs(cs32), .ir(ir32),
        .biu_req(req32), .op_sel(sel32), .biu_ready(rdy_s),
        .bus_in(bi32), .bus_out(bo32), .busy(busy32), .done(done32),
        .err(err32), .cout(c32), .zero(z32)
    );

    // BIU model: ready after a programmed number of wait cycles per transfer
    always @(negedge clk) begin
        if (!biu_req) begin
            bcnt = 0;
            biu_ready = 1'b0;
        end else begin
            if (op_sel != last_sel) bcnt = 0;
            biu_ready = (bcnt >= ((op_sel == SEL_A) ? wait_a :
                                  (op_sel == SEL_WR) ? wait_w : 0));
            bcnt++;
        end
        last_sel = op_sel;
    end

    function automatic logic [31:0] mk(input logic [2:0] op, input logic [1:0] md,
                                       input logic [15:0] imm);
        return {op, md, 11'b0, imm};
    endfunction

    task automatic run_op(input logic [31:0] irv, input logic [15:0] av, input logic [15:0] bv,
                          input int wa, output int cyc, output logic [15:0] wb,
                          output int reqa, output logic cf, output logic zf);
        a_val = av; b_val = bv; wait_a = wa; wait_w = 0;
        ir = irv; cs = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0; ir = $urandom;
        cyc = 1; wb = 'x; reqa = 0;
        while (!done && cyc < 50) begin
            if (biu_req && op_sel == SEL_WR) wb = bus_out;
            if (biu_req && op_sel == SEL_A) reqa++;
            @(posedge clk); #1;
            cyc++;
        end
        cf = cout; zf = zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [23:0] v;
        cs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        v = {biu_req, op_sel, bus_out, busy, done, err, cout, zero};
        total_cnt++;
        if (v !== 24'h0) $display("FAIL reset_outputs: got %h want 000000", v);
        else pass_cnt++;
        cs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_no_start: busy=%b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_add_imm();
        int cyc, reqa;
        logic [15:0] wb;
        logic cf, zf;
        run_op(mk(OP_ADD, MODE_IMM, 16'h0001), 16'h1234, 16'h0000, 0, cyc, wb, reqa, cf, zf);
        total_cnt++;
        if (wb !== 16'h1235) $display("FAIL add_imm_wb: got %h want 1235", wb);
        else pass_cnt++;
        total_cnt++;
        if (cf !== 1'b0 || zf !== 1'b0) $display("FAIL add_imm_flags: cout=%b zero=%b want 0 0", cf, zf);
        else pass_cnt++;
        total_cnt++;
        if (cyc !== 5) $display("FAIL add_imm_latency: got %0d want 5", cyc);
        else pass_cnt++;
    endtask

    task automatic test_add_rr();
        int cyc, reqa;
        logic [15:0] wb;
        logic cf, zf;
        run_op(mk(OP_ADD, MODE_RR, 16'h7777), 16'hFFFF, 16'h0001, 0, cyc, wb, reqa, cf, zf);
        total_cnt++;
        if (wb !== 16'h0000) $display("FAIL add_rr_wb: got %h want 0000", wb);
        else pass_cnt++;
        total_cnt++;
        if (cf !== 1'b1 || zf !== 1'b1) $display("FAIL add_rr_flags: cout=%b zero=%b want 1 1", cf, zf);
        else pass_cnt++;
        total_cnt++;
        if (cyc !== 6) $display("FAIL add_rr_latency: got %0d want 6", cyc);
        else pass_cnt++;
    endtask

    task automatic test_sub_wait();
        int cyc, reqa;
        logic [15:0] wb;
        logic cf, zf;
        run_op(mk(OP_SUB, MODE_IMM, 16'h0005), 16'h0003, 16'h0000, 3, cyc, wb, reqa, cf, zf);
        total_cnt++;
        if (wb !== 16'hFFFE) $display("FAIL sub_wait_wb: got %h want fffe", wb);
        else pass_cnt++;
        total_cnt++;
        if (cf !== 1'b1) $display("FAIL sub_wait_borrow: got %b want 1", cf);
        else pass_cnt++;
        total_cnt++;
        if (cyc !== 8) $display("FAIL sub_wait_latency: got %0d want 8", cyc);
        else pass_cnt++;
        total_cnt++;
        if (reqa !== 4) $display("FAIL sub_wait_req_stable: got %0d want 4", reqa);
        else pass_cnt++;
    endtask

    task automatic test_ops();
        int cyc, reqa;
        logic [15:0] wb;
        logic cf, zf;
        for (int i = 0; i < 7; i++) begin
            run_op(mk(t_op[i], MODE_IMM, t_b[i]), t_a[i], 16'h0000, 0, cyc, wb, reqa, cf, zf);
            total_cnt++;
            if (wb !== t_r[i]) $display("FAIL op%0d_wb: got %h want %h", t_op[i], wb, t_r[i]);
            else pass_cnt++;
            total_cnt++;
            if (cf !== 1'b0) $display("FAIL op%0d_cout: got %b want 0", t_op[i], cf);
            else pass_cnt++;
        end
    endtask

    task automatic test_bad_mode();
        logic seen = 1'b0;
        ir = {OP_ADD, MODE_BAD, 27'h0};
        cs = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0;
        seen |= biu_req;
        total_cnt++;
        if (err !== 1'b0 || busy !== 1'b1) $display("FAIL bad_dec: err=%b busy=%b want 0 1", err, busy);
        else pass_cnt++;
        @(posedge clk); #1;
        seen |= biu_req;
        total_cnt++;
        if (err !== 1'b1 || busy !== 1'b0) $display("FAIL bad_err_pulse: err=%b busy=%b want 1 0", err, busy);
        else pass_cnt++;
        @(posedge clk); #1;
        seen |= biu_req;
        total_cnt++;
        if (err !== 1'b0 || busy !== 1'b0) $display("FAIL bad_after: err=%b busy=%b want 0 0", err, busy);
        else pass_cnt++;
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL bad_no_req: got %b want 0", seen);
        else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        int cyc = 1;
        logic [15:0] wb = 'x;
        a_val = 16'h0010; wait_a = 0; wait_w = 0;
        ir = mk(OP_ADD, MODE_IMM, 16'h0020);
        cs = 1'b1;
        @(posedge clk); #1;
        ir = mk(OP_SUB, MODE_IMMO, 16'h5555);
        while (!done && cyc < 50) begin
            if (biu_req && op_sel == SEL_WR) wb = bus_out;
            @(posedge clk); #1;
            cyc++;
        end
        total_cnt++;
        if (wb !== 16'h0030 || cyc !== 5) $display("FAIL busy_ignore: wb=%h cyc=%0d want 0030 5", wb, cyc);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL cs_in_done: busy=%b want 0", busy);
        else pass_cnt++;
        cs = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_wb();
        int n = 0, cyc, reqa;
        logic [15:0] wb;
        logic cf, zf;
        logic [23:0] v;
        a_val = 16'h0001; wait_a = 0; wait_w = 1000;
        ir = mk(OP_ADD, MODE_IMM, 16'h0001);
        cs = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0;
        while (!(biu_req && op_sel == SEL_WR) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total_cnt++;
        if (!(biu_req && op_sel == SEL_WR)) $display("FAIL rst_wb_reach: req=%b sel=%b want 1 10", biu_req, op_sel);
        else pass_cnt++;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        v = {biu_req, op_sel, bus_out, busy, done, err, cout, zero};
        total_cnt++;
        if (v !== 24'h0) $display("FAIL rst_wb_async: got %h want 000000", v);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        wait_w = 0;
        @(posedge clk); #1;
        total_cnt++;
        if (biu_req !== 1'b0) $display("FAIL rst_wb_no_write: req=%b want 0", biu_req);
        else pass_cnt++;
        run_op(mk(OP_SHL, MODE_IMMO, 16'h0004), 16'hFFFF, 16'h0000, 0, cyc, wb, reqa, cf, zf);
        total_cnt++;
        if (wb !== 16'h0000 || zf !== 1'b1) $display("FAIL shl_immo_wb: wb=%h zero=%b want 0000 1", wb, zf);
        else pass_cnt++;
        total_cnt++;
        if (cyc !== 4) $display("FAIL shl_immo_latency: got %0d want 4", cyc);
        else pass_cnt++;
        total_cnt++;
        if (reqa !== 0) $display("FAIL shl_immo_no_read: got %0d want 0", reqa);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        int cyc = 1, d8 = 0, d32 = 0;
        logic [7:0]  w8 = 'x;
        logic [31:0] w32 = 'x;
        ir8  = {OP_SHR, MODE_RR, 27'h0};
        ir32 = {OP_SHR, MODE_RR, 35'h0};
        cs8 = 1'b1; cs32 = 1'b1;
        @(posedge clk); #1;
        cs8 = 1'b0; cs32 = 1'b0;
        while (cyc < 20 && (d8 == 0 || d32 == 0)) begin
            if (req8 && sel8 == SEL_WR) w8 = bo8;
            if (req32 && sel32 == SEL_WR) w32 = bo32;
            if (done8 && d8 == 0) d8 = cyc;
            if (done32 && d32 == 0) d32 = cyc;
            @(posedge clk); #1;
            cyc++;
        end
        total_cnt++;
        if (w8 !== 8'h01 || d8 !== 6) $display("FAIL sweep_dw8: wb=%h cyc=%0d want 01 6", w8, d8);
        else pass_cnt++;
        total_cnt++;
        if (w32 !== 32'h1 || d32 !== 6) $display("FAIL sweep_dw32: wb=%h cyc=%0d want 00000001 6", w32, d32);
        else pass_cnt++;
        total_cnt++;
        if ({busy8, err8, c8, z8, busy32, err32, c32, z32} !== 8'h0)
            $display("FAIL sweep_flags: got %b want 00000000",
                     {busy8, err8, c8, z8, busy32, err32, c32, z32});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_add_rr();
        test_sub_wait();
        test_ops();
        test_bad_mode();
        test_busy_ignore();
        test_reset_wb();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
